// File: rtl/mem_io_bridge.sv
// ----------------------------------------------------------------------------
// mem_io_bridge
//
// Sits directly behind the CPU core's byte-wide memory bus and splits each bus
// cycle between on-chip RAM and a small block of memory-mapped I/O.
//
// Address map (only mem_a[17:0] is decoded, bits 31:18 are ignored):
//   mem_a[17:16] != 2'b11  : RAM, byte address mem_a[RAM_ADDR_W-1:0]
//   0x30000 read           : head byte of the UART RX queue (pops it)
//   0x30000 write          : push byte into the UART TX FIFO (0x00 dropped)
//   0x30004 read           : snapshot cycle counter, return byte 0
//   0x30005..0x30007 read  : bytes 1..3 of the existing snapshot
//   0x30004 write          : set sticky prog_stop and push 0x00 into TX FIFO
//   any other I/O address  : reads 0x00, writes are dropped
//
// Ports:
//   clk_in, rst_in        system clock, asynchronous active-low reset
//   mem_a/mem_dout/mem_wr CPU bus request (address, write data, write strobe)
//   mem_din               read data, valid the cycle after the request
//   cpu_rdy_out           low stalls the CPU (TX FIFO full and a push pending)
//   ram_a/ram_we/ram_wdata/ram_rdata  on-chip RAM port (1-cycle read latency)
//   rx_data/rx_empty/rx_pop           UART RX queue head and consume strobe
//   tx_data/tx_valid/tx_ready         UART TX handshake out of the FIFO
//   prog_stop             sticky flag raised by a write to 0x30004
// ----------------------------------------------------------------------------
module mem_io_bridge #(
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int RAM_ADDR_W    = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           mem_a,
  input  logic [7:0]            mem_dout,
  input  logic                  mem_wr,
  output logic [7:0]            mem_din,
  output logic                  cpu_rdy_out,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  rx_pop,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  prog_stop
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] PTR_ONE = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};

  // Source of the byte returned on mem_din, chosen at request time.
  typedef enum logic [2:0] {
    RSEL_RAM  = 3'd0,
    RSEL_RX   = 3'd1,
    RSEL_CNT0 = 3'd2,
    RSEL_CNT1 = 3'd3,
    RSEL_CNT2 = 3'd4,
    RSEL_CNT3 = 3'd5,
    RSEL_ZERO = 3'd6
  } rsel_e;

  // Address decode
  logic        io_s;
  logic [15:0] io_off_s;
  logic        rx_sel_s;
  logic        cnt_sel_s;
  logic        stop_sel_s;
  logic        unused_addr_s;

  // Handshake / control
  logic        tx_push_req_s;
  logic        tx_push_s;
  logic        tx_pop_s;
  logic [7:0]  tx_push_data_s;
  logic        rdy_s;
  logic        rx_rd_s;
  logic        cnt_load_s;

  // TX FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [TX_DEPTH_LOG2:0] wr_ptr_r;
  logic [TX_DEPTH_LOG2:0] rd_ptr_r;
  logic [7:0]             fifo_mem_r [TX_DEPTH];
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  // Read path and I/O state
  rsel_e       rsel_r;
  rsel_e       rsel_next_s;
  logic [7:0]  rx_byte_r;
  logic [31:0] cycle_cnt_r;
  logic [31:0] cnt_snap_r;
  logic        prog_stop_r;
  logic [7:0]  mem_din_s;

  // Upper address bits are architecturally don't-care.
  assign unused_addr_s = ^mem_a[31:18];

  assign io_s       = (mem_a[17:16] == 2'b11);
  assign io_off_s   = mem_a[15:0];
  assign rx_sel_s   = io_s && (io_off_s == 16'h0000);
  assign cnt_sel_s  = io_s && (io_off_s[15:2] == 14'h0001);
  assign stop_sel_s = io_s && (io_off_s == 16'h0004);

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[TX_DEPTH_LOG2] != rd_ptr_r[TX_DEPTH_LOG2]) &&
                        (wr_ptr_r[TX_DEPTH_LOG2-1:0] == rd_ptr_r[TX_DEPTH_LOG2-1:0]);

  // A write of 0x00 to the TX data port is a no-op; the stop port always
  // queues a 0x00 terminator for the host side.
  assign tx_push_req_s  = mem_wr && ((rx_sel_s && (mem_dout != 8'h00)) || stop_sel_s);
  assign tx_push_data_s = stop_sel_s ? 8'h00 : mem_dout;
  assign tx_pop_s       = (!fifo_empty_s) && tx_ready;

  // A pop in the same cycle frees a slot, so only stall when full with no pop.
  assign rdy_s      = !(fifo_full_s && tx_push_req_s && !tx_pop_s);
  assign tx_push_s  = tx_push_req_s && rdy_s;
  assign rx_rd_s    = (!mem_wr) && rx_sel_s && rdy_s;
  assign cnt_load_s = (!mem_wr) && stop_sel_s && rdy_s;

  assign cpu_rdy_out = rdy_s;
  assign ram_a       = mem_a[RAM_ADDR_W-1:0];
  assign ram_we      = mem_wr && (!io_s) && rdy_s;
  assign ram_wdata   = mem_dout;
  assign rx_pop      = rx_rd_s && (!rx_empty);
  assign tx_valid    = !fifo_empty_s;
  assign tx_data     = fifo_mem_r[rd_ptr_r[TX_DEPTH_LOG2-1:0]];
  assign prog_stop   = prog_stop_r;
  assign mem_din     = mem_din_s;

  // Select which source will drive mem_din on the next cycle.
  always_comb begin
    rsel_next_s = RSEL_ZERO;
    if (mem_wr) begin
      rsel_next_s = RSEL_ZERO;
    end else if (!io_s) begin
      rsel_next_s = RSEL_RAM;
    end else if (rx_sel_s) begin
      rsel_next_s = RSEL_RX;
    end else if (cnt_sel_s) begin
      case (io_off_s[1:0])
        2'd0:    rsel_next_s = RSEL_CNT0;
        2'd1:    rsel_next_s = RSEL_CNT1;
        2'd2:    rsel_next_s = RSEL_CNT2;
        2'd3:    rsel_next_s = RSEL_CNT3;
        default: rsel_next_s = RSEL_ZERO;
      endcase
    end else begin
      rsel_next_s = RSEL_ZERO;
    end
  end

  // Read-data mux driven by the select captured on the previous cycle.
  always_comb begin
    mem_din_s = 8'h00;
    case (rsel_r)
      RSEL_RAM:  mem_din_s = ram_rdata;
      RSEL_RX:   mem_din_s = rx_byte_r;
      RSEL_CNT0: mem_din_s = cnt_snap_r[7:0];
      RSEL_CNT1: mem_din_s = cnt_snap_r[15:8];
      RSEL_CNT2: mem_din_s = cnt_snap_r[23:16];
      RSEL_CNT3: mem_din_s = cnt_snap_r[31:24];
      default:   mem_din_s = 8'h00;
    endcase
  end

  // Capture read select and the RX byte whenever the CPU is not stalled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rsel_r    <= RSEL_ZERO;
      rx_byte_r <= 8'h00;
    end else if (rdy_s) begin
      rsel_r <= rsel_next_s;
      if (rx_rd_s) begin
        rx_byte_r <= rx_empty ? 8'h00 : rx_data;
      end
    end
  end

  // Free-running cycle counter and its CPU-visible snapshot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt_r <= 32'h0000_0000;
      cnt_snap_r  <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      if (cnt_load_s) begin
        cnt_snap_r <= cycle_cnt_r;
      end
    end
  end

  // TX FIFO pointers; reset empties the FIFO regardless of its contents.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (tx_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (tx_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // TX FIFO storage; contents are only observable through the pointers.
  always_ff @(posedge clk_in) begin
    if (tx_push_s) begin
      fifo_mem_r[wr_ptr_r[TX_DEPTH_LOG2-1:0]] <= tx_push_data_s;
    end
  end

  // Sticky program-stop flag, set only when the stop write is accepted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prog_stop_r <= 1'b0;
    end else if (tx_push_s && stop_sel_s) begin
      prog_stop_r <= 1'b1;
    end
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU core's byte-wide memory bus.
- Decodes each bus cycle to on-chip RAM (addresses below 0x30000) or to memory-mapped I/O (mem_a[17:16]==2'b11).
- Implements the UART TX FIFO, the RX byte read port, the cycle counter at 0x30004 and the program-stop flag.
- Returns read data one cycle after the request, and throttles the CPU through cpu_rdy_out when TX buffering is exhausted.

Parameters:
- TX_DEPTH_LOG2, 3, log2 of TX FIFO depth (8 entries).
- RAM_ADDR_W, 17, RAM byte-address width (128 KB).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-low
- mem_a  in  32  CPU byte address (bits 17:0 decoded)
- mem_dout  in  8  CPU write data
- mem_wr  in  1  1=write, 0=read
- mem_din  out  8  read data to CPU, valid the cycle after the request
- cpu_rdy_out  out  1  CPU ready; low pauses the CPU
- ram_a  out  RAM_ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, 1-cycle latency
- rx_data  in  8  UART received byte at head of RX queue
- rx_empty  in  1  RX queue empty
- rx_pop  out  1  consume rx_data (1-cycle pulse)
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts when tx_valid&&tx_ready
- prog_stop  out  1  sticky: program has written 0x30004

Behaviour:
- Decode:
  - io = (mem_a[17:16]==2'b11).
  - RAM access when !io: ram_a = mem_a[RAM_ADDR_W-1:0] (combinational); ram_we = mem_wr && !io && cpu_rdy_out; ram_wdata = mem_dout.
  - I/O accesses never assert ram_we.
- Read path:
  - On each cycle with cpu_rdy_out=1, register rsel. Encodings: RAM=0; RX=1 (0x30000); CNT0..CNT3=2..5 (0x30004..0x30007); ZERO=6 (any other I/O address or a write).
  - mem_din is combinational from the registered rsel:
    - RAM: ram_rdata.
    - RX: the rx_data byte latched at request time, or 0x00 if rx_empty was 1.
    - CNTk: byte k of cnt_snap.
    - ZERO: 0x00.
- RX: a read of 0x30000 with rx_empty=0 and cpu_rdy_out=1 pulses rx_pop for exactly that cycle. With rx_empty=1 there is no pop.
- Cycle counter:
  - 32-bit cycle_cnt increments every clock after reset and wraps at 0xFFFFFFFF to 0.
  - A read of 0x30004 loads cnt_snap <= cycle_cnt; byte 0 returned next cycle comes from that snapshot.
  - Reads of 0x30005..0x30007 return bytes of the existing snapshot and do not reload it.
- TX FIFO:
  - Depth 2^TX_DEPTH_LOG2, circular rd/wr pointers with an extra wrap bit.
  - A write to 0x30000 with mem_dout!=0x00 pushes mem_dout; a write of 0x00 is ignored.
  - A write to 0x30004 sets prog_stop and pushes 0x00.
  - tx_valid = !empty; tx_data = head. Pop on tx_valid&&tx_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and count is unchanged.
- Backpressure:
  - cpu_rdy_out = !(fifo_full && tx_push_req && !tx_pop), where tx_push_req is the combinational decode of the current bus cycle.
  - When low, the CPU holds the bus: no RAM write, no rx_pop, no rsel/snapshot update, no push.
  - The request retries the next cycle.
- prog_stop: sticky until reset; later bus traffic is still serviced normally.
- Reset (asynchronous, rst_in=0):
  - FIFO empty, so tx_valid=0.
  - rsel=ZERO (mem_din=0x00), cycle_cnt=0, cnt_snap=0, prog_stop=0, rx_pop=0, ram_we=0.
  - cpu_rdy_out=1 once rst_in deasserts.
  - A reset mid-transfer discards all FIFO contents.
- Address bits 31:18 are ignored. Unused I/O addresses read 0x00, and writes to them are dropped.

Test Plan:
- After reset, write 0x5A to address 0x00100, then read 0x00100 -> ram_we=1 with ram_a=0x00100 on the write cycle; mem_din=0x5A on the cycle after the read.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx stream is 0x41, 0x42 only; no push for 0x00.
- Hold tx_ready=0 and write 9 non-zero bytes to 0x30000 -> first 8 accepted; cpu_rdy_out=0 on the 9th. Raise tx_ready for 1 cycle -> 9th accepted and cpu_rdy_out=1; bytes drain in order.
- Run 300 cycles after reset, then read 0x30004..0x30007 back-to-back -> the four bytes assemble to the cycle_cnt value at the 0x30004 request cycle (≈300), not incrementing across the bytes.
- rx_empty=0 with rx_data=0x33, read 0x30000 -> rx_pop pulses one cycle and mem_din=0x33 next cycle. Repeat with rx_empty=1 -> mem_din=0x00 and no pop.
- Write 0x30004, then assert rst_in=0 mid-drain -> prog_stop=1 and 0x00 queued before reset; after reset prog_stop=0, tx_valid=0, mem_din=0x00.
